// File: rtl/row_dispatch_ctrl.sv
// row_dispatch_ctrl
// Round-robin row scheduler for the row-wise sparse x dense multiply array.
// Sparse-row descriptors (nonzero count per row) arrive over a valid/ready
// handshake. Each row is issued to the PE selected by a rotating one-hot
// pointer, and issue waits while that PE is busy. After the last row the
// controller waits for every PE to go idle and then pulses done.
//
// Build option:
//   SKIP_EMPTY_ROWS_EN - when defined, rows with a zero nonzero count are
//                        consumed in FETCH without being dispatched and
//                        without moving the pointer. When undefined, empty
//                        rows are dispatched like any other row (pe_nnz = 0).

module row_dispatch_ctrl #(
    parameter int NUM_PE = 280,
    parameter int ROW_W  = 16,
    parameter int NNZ_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ROW_W-1:0]  num_rows,
    input  logic              rp_valid,
    input  logic [NNZ_W-1:0]  rp_nnz,
    output logic              rp_ready,
    input  logic [NUM_PE-1:0] pe_busy,
    output logic              pe_load,
    output logic [NUM_PE-1:0] pe_sel,
    output logic [ROW_W-1:0]  pe_row_idx,
    output logic [NNZ_W-1:0]  pe_nnz,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        DISPATCH = 2'd2,
        DRAIN    = 2'd3
    } state_t;

    // Pointer value that selects PE0.
    localparam logic [NUM_PE-1:0] PTR_INIT = {{(NUM_PE-1){1'b0}}, 1'b1};

    // Rotate the one-hot pointer left by one; the top PE wraps to PE0.
    function automatic logic [NUM_PE-1:0] rotl1(input logic [NUM_PE-1:0] v);
        return {v[NUM_PE-2:0], v[NUM_PE-1]};
    endfunction

    state_t              state_r;
    state_t              state_s;

    logic [NUM_PE-1:0]   ptr_r;
    logic [ROW_W-1:0]    num_rows_r;
    logic [ROW_W-1:0]    row_cnt_r;
    logic [ROW_W-1:0]    row_idx_r;
    logic [NNZ_W-1:0]    nnz_r;

    logic                pe_load_r;
    logic [NUM_PE-1:0]   pe_sel_r;
    logic [ROW_W-1:0]    pe_row_idx_r;
    logic [NNZ_W-1:0]    pe_nnz_r;
    logic                done_r;

    logic                job_start_s;  // start accepted in IDLE
    logic                take_s;       // descriptor latched for dispatch
    logic                skip_s;       // empty descriptor consumed in place
    logic                issue_s;      // row handed to the PE under ptr
    logic                finish_s;     // all PEs idle after the last row
    logic                last_row_s;   // row_cnt_r addresses the final row
    logic                ready_s;

    // The row counter never exceeds num_rows_r, so a full 2^ROW_W-1 row job
    // ends at the all-ones count without wrapping.
    assign last_row_s = (row_cnt_r == (num_rows_r - ROW_W'(1)));

    // Next-state decode and single-cycle control strobes.
    always_comb begin
        state_s     = state_r;
        job_start_s = 1'b0;
        take_s      = 1'b0;
        skip_s      = 1'b0;
        issue_s     = 1'b0;
        finish_s    = 1'b0;
        ready_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    job_start_s = 1'b1;
                    if (num_rows == {ROW_W{1'b0}}) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                // Ready is withheld during reset so a descriptor offered in
                // the reset cycle is left for the next job.
                ready_s = ~rst;
                if (rp_valid && !rst) begin
`ifdef SKIP_EMPTY_ROWS_EN
                    if (rp_nnz == {NNZ_W{1'b0}}) begin
                        skip_s = 1'b1;
                        if (last_row_s) begin
                            state_s = DRAIN;
                        end else begin
                            state_s = FETCH;
                        end
                    end else begin
                        take_s  = 1'b1;
                        state_s = DISPATCH;
                    end
`else
                    take_s  = 1'b1;
                    state_s = DISPATCH;
`endif
                end else begin
                    state_s = FETCH;
                end
            end
            DISPATCH: begin
                // Strict round-robin: a busy target holds the row rather than
                // looking for another free PE.
                if ((pe_busy & ptr_r) == {NUM_PE{1'b0}}) begin
                    issue_s = 1'b1;
                    if (last_row_s) begin
                        state_s = DRAIN;
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = DISPATCH;
                end
            end
            DRAIN: begin
                if (pe_busy == {NUM_PE{1'b0}}) begin
                    finish_s = 1'b1;
                    state_s  = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Job bookkeeping: row count, pointer, and the descriptor awaiting issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r      <= PTR_INIT;
            num_rows_r <= {ROW_W{1'b0}};
            row_cnt_r  <= {ROW_W{1'b0}};
            row_idx_r  <= {ROW_W{1'b0}};
            nnz_r      <= {NNZ_W{1'b0}};
        end else begin
            if (job_start_s) begin
                num_rows_r <= num_rows;
                row_cnt_r  <= {ROW_W{1'b0}};
                ptr_r      <= PTR_INIT;
            end
            if (take_s) begin
                nnz_r     <= rp_nnz;
                row_idx_r <= row_cnt_r;
            end
            if (skip_s || issue_s) begin
                row_cnt_r <= row_cnt_r + ROW_W'(1);
            end
            if (issue_s) begin
                ptr_r <= rotl1(ptr_r);
            end
        end
    end

    // Registered PE dispatch interface and completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pe_load_r    <= 1'b0;
            pe_sel_r     <= {NUM_PE{1'b0}};
            pe_row_idx_r <= {ROW_W{1'b0}};
            pe_nnz_r     <= {NNZ_W{1'b0}};
            done_r       <= 1'b0;
        end else begin
            pe_load_r <= issue_s;
            pe_sel_r  <= issue_s ? ptr_r : {NUM_PE{1'b0}};
            done_r    <= finish_s;
            if (issue_s) begin
                pe_row_idx_r <= row_idx_r;
                pe_nnz_r     <= nnz_r;
            end
        end
    end

    assign rp_ready   = ready_s;
    assign busy       = (state_r != IDLE);
    assign pe_load    = pe_load_r;
    assign pe_sel     = pe_sel_r;
    assign pe_row_idx = pe_row_idx_r;
    assign pe_nnz     = pe_nnz_r;
    assign done       = done_r;

endmodule

// File: tb/tb_row_dispatch_ctrl.sv
// Testbench for row_dispatch_ctrl with NUM_PE=4. A vector table of rows
// (input nnz, expected dispatch) drives four jobs; zero-row and reset-abort
// cases are hand-written sequences. Expectations follow SKIP_EMPTY_ROWS_EN.

module tb_row_dispatch_ctrl;

    localparam int NUM_PE = 4;
    localparam int ROW_W  = 16;
    localparam int NNZ_W  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [ROW_W-1:0]  num_rows;
    logic              rp_valid;
    logic [NNZ_W-1:0]  rp_nnz;
    logic              rp_ready;
    logic [NUM_PE-1:0] pe_busy;
    logic              pe_load;
    logic [NUM_PE-1:0] pe_sel;
    logic [ROW_W-1:0]  pe_row_idx;
    logic [NNZ_W-1:0]  pe_nnz;
    logic              busy;
    logic              done;

    row_dispatch_ctrl #(.NUM_PE(NUM_PE), .ROW_W(ROW_W), .NNZ_W(NNZ_W)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .rp_valid(rp_valid), .rp_nnz(rp_nnz), .rp_ready(rp_ready),
        .pe_busy(pe_busy), .pe_load(pe_load), .pe_sel(pe_sel),
        .pe_row_idx(pe_row_idx), .pe_nnz(pe_nnz), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NUM_PE-1:0] sel;
        logic [ROW_W-1:0]  idx;
        logic [NNZ_W-1:0]  nnz;
        int                cyc;
    } load_t;

    typedef struct {
        logic [NNZ_W-1:0]  nnz;       // descriptor input
        logic              exp_load;  // row produces a dispatch
        logic [NUM_PE-1:0] exp_sel;
        logic [ROW_W-1:0]  exp_idx;
        logic [NNZ_W-1:0]  exp_nnz;
    } vec_t;

    typedef struct {
        int first;
        int nrows;
        bit toggle;
        bit stall;
    } job_t;

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    int    done_cnt = 0;
    int    done_cyc = 0;
    int    busy_cyc = 0;
    int    rdy_cyc  = 0;
    int    oh_err   = 0;
    int    sel_err  = 0;
    logic  hs_last  = 1'b0;
    logic  mon_en   = 1'b0;
    load_t loads[$];
    logic [NNZ_W-1:0] feed[$];

    vec_t rows[18];
    job_t jobs[4];

    // Cycle counter used to time dispatches and done.
    always @(posedge clk) cyc <= cyc + 1;

    // Mid-cycle monitor: logs dispatches, done, handshakes and invariants.
    always @(negedge clk) begin
        hs_last <= rp_valid & rp_ready;
        if (mon_en) begin
            if (pe_load) loads.push_back('{pe_sel, pe_row_idx, pe_nnz, cyc});
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (busy) busy_cyc <= busy_cyc + 1;
            if (rp_ready) rdy_cyc <= rdy_cyc + 1;
            if (!$onehot(dut.ptr_r)) oh_err <= oh_err + 1;
            if (pe_load ? !$onehot(pe_sel) : (pe_sel != '0)) sel_err <= sel_err + 1;
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    // Runs one job from the feed queue until done or a cycle budget expires.
    task automatic run_job(input logic [ROW_W-1:0] nrows, input bit toggle,
                           input bit stall, output int drop_cyc);
        int fp;
        int stall_left;
        bit stalled;
        bit fin;
        int base_done;
        int base_load;
        base_done  = done_cnt;
        base_load  = loads.size();
        num_rows   = nrows;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        fp         = 0;
        stall_left = 0;
        stalled    = 1'b0;
        fin        = 1'b0;
        drop_cyc   = -1;
        for (int k = 0; k < 400 && !fin; k++) begin
            rp_valid = (fp < feed.size()) && (!toggle || (k % 2 == 0));
            rp_nnz   = (fp < feed.size()) ? feed[fp] : 8'd0;
            start    = toggle && (k == 3 || k == 7);
            num_rows = start ? 16'd9 : nrows;
            tick();
            if (hs_last) fp++;
            if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) begin
                    pe_busy  = 4'b0000;
                    drop_cyc = cyc;
                end
            end else if (stall && !stalled && (loads.size() - base_load == 1)) begin
                pe_busy    = 4'b0010;
                stall_left = 5;
                stalled    = 1'b1;
            end
            if (done_cnt != base_done) fin = 1'b1;
        end
        rp_valid = 1'b0;
        start    = 1'b0;
        num_rows = nrows;
        chk("job_done_within_budget", longint'(fin), 1);
        chk("rows_consumed", longint'(fp), longint'(feed.size()));
    endtask

    initial begin
        int drop;
        int bl;
        int ne;
        int hs;
        int b_done;
        int b_busy;
        int b_rdy;

        // Row table: input nnz, whether it dispatches, expected sel/idx/nnz.
        // Job 0: round-robin with wrap.
        rows[0]  = '{8'd3, 1'b1, 4'b0001, 16'd0, 8'd3};
        rows[1]  = '{8'd3, 1'b1, 4'b0010, 16'd1, 8'd3};
        rows[2]  = '{8'd3, 1'b1, 4'b0100, 16'd2, 8'd3};
        rows[3]  = '{8'd3, 1'b1, 4'b1000, 16'd3, 8'd3};
        rows[4]  = '{8'd3, 1'b1, 4'b0001, 16'd4, 8'd3};
        rows[5]  = '{8'd3, 1'b1, 4'b0010, 16'd5, 8'd3};
        // Job 1: stall on PE1.
        rows[6]  = '{8'd1, 1'b1, 4'b0001, 16'd0, 8'd1};
        rows[7]  = '{8'd1, 1'b1, 4'b0010, 16'd1, 8'd1};
        rows[8]  = '{8'd1, 1'b1, 4'b0100, 16'd2, 8'd1};
        // Job 2: empty rows.
`ifdef SKIP_EMPTY_ROWS_EN
        rows[9]  = '{8'd2, 1'b1, 4'b0001, 16'd0, 8'd2};
        rows[10] = '{8'd0, 1'b0, 4'b0000, 16'd0, 8'd0};
        rows[11] = '{8'd0, 1'b0, 4'b0000, 16'd0, 8'd0};
        rows[12] = '{8'd4, 1'b1, 4'b0010, 16'd3, 8'd4};
`else
        rows[9]  = '{8'd2, 1'b1, 4'b0001, 16'd0, 8'd2};
        rows[10] = '{8'd0, 1'b1, 4'b0010, 16'd1, 8'd0};
        rows[11] = '{8'd0, 1'b1, 4'b0100, 16'd2, 8'd0};
        rows[12] = '{8'd4, 1'b1, 4'b1000, 16'd3, 8'd4};
`endif
        // Job 3: back-pressure with ignored start pulses.
        rows[13] = '{8'd1, 1'b1, 4'b0001, 16'd0, 8'd1};
        rows[14] = '{8'd2, 1'b1, 4'b0010, 16'd1, 8'd2};
        rows[15] = '{8'd3, 1'b1, 4'b0100, 16'd2, 8'd3};
        rows[16] = '{8'd4, 1'b1, 4'b1000, 16'd3, 8'd4};
        rows[17] = '{8'd5, 1'b1, 4'b0001, 16'd4, 8'd5};
        jobs[0] = '{0, 6, 1'b0, 1'b0};
        jobs[1] = '{6, 3, 1'b0, 1'b1};
        jobs[2] = '{9, 4, 1'b0, 1'b0};
        jobs[3] = '{13, 5, 1'b1, 1'b0};

        rst      = 1'b1;
        start    = 1'b0;
        num_rows = 16'd0;
        rp_valid = 1'b0;
        rp_nnz   = 8'd0;
        pe_busy  = 4'b0000;
        tick();
        tick();
        tick();
        chk("reset_outputs_zero",
            longint'({rp_ready, pe_load, pe_sel, pe_row_idx, pe_nnz, busy, done}), 0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();
        chk("idle_outputs_zero",
            longint'({rp_ready, pe_load, pe_sel, busy, done}), 0);

        // Table-driven jobs.
        for (int j = 0; j < 4; j++) begin
            feed.delete();
            for (int r = 0; r < jobs[j].nrows; r++) feed.push_back(rows[jobs[j].first + r].nnz);
            bl = loads.size();
            run_job(16'(jobs[j].nrows), jobs[j].toggle, jobs[j].stall, drop);
            ne = 0;
            for (int r = 0; r < jobs[j].nrows; r++) if (rows[jobs[j].first + r].exp_load) ne++;
            chk($sformatf("job%0d_load_count", j), longint'(loads.size() - bl), longint'(ne));
            ne = 0;
            for (int r = 0; r < jobs[j].nrows; r++) begin
                if (rows[jobs[j].first + r].exp_load) begin
                    if (bl + ne < loads.size()) begin
                        chk($sformatf("job%0d_row%0d_sel", j, r),
                            longint'(loads[bl + ne].sel), longint'(rows[jobs[j].first + r].exp_sel));
                        chk($sformatf("job%0d_row%0d_idx", j, r),
                            longint'(loads[bl + ne].idx), longint'(rows[jobs[j].first + r].exp_idx));
                        chk($sformatf("job%0d_row%0d_nnz", j, r),
                            longint'(loads[bl + ne].nnz), longint'(rows[jobs[j].first + r].exp_nnz));
                    end
                    ne++;
                end
            end
            if (loads.size() > bl) begin
                chk($sformatf("job%0d_done_after_last_load", j),
                    longint'(done_cyc), longint'(loads[loads.size() - 1].cyc + 1));
            end
            if (jobs[j].stall && (loads.size() - bl >= 2)) begin
                chk("stall_release_cycle", longint'(loads[bl + 1].cyc), longint'(drop + 1));
            end
            tick();
            chk($sformatf("job%0d_idle_after_done", j), longint'({busy, done}), 0);
        end

        // Zero-row job: busy for one cycle, then done, no fetch or dispatch.
        b_done = done_cnt;
        b_busy = busy_cyc;
        b_rdy  = rdy_cyc;
        bl     = loads.size();
        num_rows = 16'd0;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        chk("zero_rows_done_count", longint'(done_cnt - b_done), 1);
        chk("zero_rows_busy_cycles", longint'(busy_cyc - b_busy), 1);
        chk("zero_rows_rp_ready_cycles", longint'(rdy_cyc - b_rdy), 0);
        chk("zero_rows_loads", longint'(loads.size() - bl), 0);

        // Reset during DISPATCH of row 1: outputs clear, no done.
        feed.delete();
        num_rows = 16'd4;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        hs       = 0;
        for (int k = 0; k < 30 && hs < 2; k++) begin
            rp_valid = 1'b1;
            rp_nnz   = 8'd7;
            tick();
            if (hs_last) hs++;
        end
        chk("reset_job_handshakes", longint'(hs), 2);
        rp_valid = 1'b0;
        b_done   = done_cnt;
        rst      = 1'b1;
        tick();
        chk("midjob_reset_outputs_zero",
            longint'({rp_ready, pe_load, pe_sel, pe_row_idx, pe_nnz, busy, done}), 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("midjob_reset_no_done", longint'(done_cnt - b_done), 0);
        chk("midjob_reset_idle", longint'(busy), 0);

        // Following job restarts at PE0.
        feed.delete();
        feed.push_back(8'd5);
        feed.push_back(8'd6);
        bl = loads.size();
        run_job(16'd2, 1'b0, 1'b0, drop);
        chk("restart_load_count", longint'(loads.size() - bl), 2);
        if (loads.size() - bl >= 2) begin
            chk("restart_sel0", longint'(loads[bl].sel), 1);
            chk("restart_sel1", longint'(loads[bl + 1].sel), 2);
            chk("restart_idx1", longint'(loads[bl + 1].idx), 1);
            chk("restart_nnz1", longint'(loads[bl + 1].nnz), 6);
        end

        tick();
        chk("ptr_onehot_violations", longint'(oh_err), 0);
        chk("pe_sel_violations", longint'(sel_err), 0);
        chk("total_done_pulses", longint'(done_cnt), 6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/row_dispatch_ctrl.md
Name: row_dispatch_ctrl

Overview:
- Scheduler for the row-wise sparse x dense multiply array.
- Pulls one sparse-row descriptor (row nonzero count) per row from the row-pointer stage over a valid/ready handshake.
- Assigns each non-empty row to the next PE in round-robin order using a rotating one-hot pointer, stalling while that PE is busy.
- Reports completion once every row is issued and every PE has drained.

Parameters:
- NUM_PE, 280, number of PEs; width of the one-hot select and busy mask.
- ROW_W, 16, width of the row count and row index.
- NNZ_W, 8, width of the per-row nonzero count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  single-cycle pulse that begins a job; ignored unless the state is IDLE.
- num_rows  input  ROW_W  rows in the job; sampled on start.
- rp_valid  input  1  row descriptor valid.
- rp_nnz  input  NNZ_W  nonzero count of the current row.
- rp_ready  output  1  controller accepts a descriptor.
- pe_busy  input  NUM_PE  per-PE busy mask.
- pe_load  output  1  single-cycle dispatch strobe.
- pe_sel  output  NUM_PE  one-hot target PE; valid only with pe_load, zero otherwise.
- pe_row_idx  output  ROW_W  index of the dispatched row.
- pe_nnz  output  NNZ_W  nonzero count of the dispatched row.
- busy  output  1  high in every state except IDLE.
- done  output  1  single-cycle pulse at job end.

Behaviour:
- Reset: state IDLE; internal pointer ptr = 1 (PE0); row counter = 0.
- Reset values of outputs: rp_ready, pe_load, pe_sel, pe_row_idx, pe_nnz, busy and done are all 0.
- Reset asserted mid-job aborts the job with no done pulse. A descriptor presented in that cycle is not consumed.
- pe_load, pe_sel, pe_row_idx, pe_nnz and done are registered.
- States: IDLE, FETCH, DISPATCH, DRAIN.
- IDLE:
  - On start, latch num_rows, clear the row counter, set ptr = 1.
  - Go to FETCH, or to DRAIN when num_rows == 0.
  - start asserted in any other state has no effect.
- FETCH:
  - rp_ready = 1 (combinational from state).
  - On rp_valid with rp_nnz != 0: latch nnz and row index, go to DISPATCH.
  - On rp_valid with rp_nnz == 0 (skip): increment the row counter, issue no dispatch, leave ptr unchanged.
  - After a skip, go to DRAIN if that was the last row, otherwise stay in FETCH.
- DISPATCH:
  - rp_ready = 0.
  - If (pe_busy & ptr) == 0: on the next cycle pe_load = 1, pe_sel = ptr, pe_row_idx and pe_nnz = latched values.
  - In the same decision cycle, increment the row counter and rotate ptr left by 1. Bit NUM_PE-1 wraps to bit 0.
  - Then go to DRAIN if that was the last row, else to FETCH.
  - If the target PE is busy, hold: no pointer advance and no pe_load. There is no fallback to another PE.
- DRAIN:
  - When pe_busy == 0 (sampled after the final pe_load has been registered), pulse done for 1 cycle and go to IDLE.
- Latency and throughput:
  - From the handshake edge to pe_load high is 2 cycles when the target PE is free.
  - Peak rate is one row per 2 cycles.
- ptr is always exactly one-hot; the bench checks this every cycle.
- The row counter is ROW_W bits wide. num_rows = 2^ROW_W-1 must complete with no overflow.

Optional Feature:
- Macro: SKIP_EMPTY_ROWS_EN.
- Defined: empty rows are consumed in FETCH without dispatch, as described above.
- Undefined: rows with rp_nnz == 0 are handled exactly like other rows. They go through DISPATCH, produce pe_load with pe_nnz = 0, and advance ptr.

Test Plan:
- Round-robin with wrap (NUM_PE=4, num_rows=6, all nnz=3, pe_busy=0): pe_sel sequence 0001,0010,0100,1000,0001,0010; pe_row_idx 0..5; done exactly 1 cycle after DRAIN sees busy clear.
- Stall on busy target (NUM_PE=4): pe_busy[1]=1 for 5 cycles while row 1 targets PE1; no pe_load during the stall, then pe_sel=0010 on the cycle after busy drops, with no skip to PE2.
- Empty-row skip (SKIP_EMPTY_ROWS_EN defined): nnz sequence 2,0,0,4 gives two loads, to PE0 (row 0) and PE1 (row 3); without the macro, four loads to PE0..PE3 with pe_nnz 2,0,0,4.
- Zero-row job: start with num_rows=0 and pe_busy=0 gives no rp_ready and no pe_load; busy high for 1 cycle, then done.
- Back-pressure: rp_valid toggles every other cycle; no descriptor lost or duplicated; pe_row_idx strictly increasing; start pulses while busy are ignored.
- Reset mid-job: rst asserted during DISPATCH gives all outputs 0 on the next cycle and no done; a following job restarts at pe_sel=0001.
